// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch front end: one instruction in flight,
// req/gnt + rvalid memory handshake, next-PC selection from decode.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   imem_req/addr       fetch request and address (stable while req=1)
//   imem_gnt            memory accepted the request
//   imem_rvalid/rdata   instruction response
//   instr_valid/ready   handshake toward decode
//   instr, instr_pc     buffered instruction and its PC
//   op, funct3,funct7_5 decoded field slices of instr
//   pcsrc, imm_op       next-PC select and immediate, used on acceptance
//   fetch_misaligned    sticky flag: a non word-aligned target was chosen
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] imm_op,
    output logic            fetch_misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

    // Target selection; 2'b11 falls back to sequential.
    always_comb begin
        next_pc = ipc_q + XLEN'(4);
        unique case (pcsrc)
            2'b01:   next_pc = ipc_q + imm_op;
            2'b10:   next_pc = imm_op;
            default: next_pc = ipc_q + XLEN'(4);
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = mis_q;
        unique case (state_q)
            // rvalid alongside gnt cannot belong to this request: ignored.
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Reset forces state to REQ, so mask the request while rst is high.
    assign imem_req         = (state_q == S_REQ) && !rst;
    assign imem_addr        = pc_q;
    assign instr_valid      = (state_q == S_HOLD);
    assign instr            = instr_q;
    assign instr_pc         = ipc_q;
    assign op               = instr_q[6:0];
    assign funct3           = instr_q[14:12];
    assign funct7_5         = instr_q[30];
    assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// fetch streams checked against a next-PC reference model.
module tb_fetch_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [1:0]      pcsrc = 2'b00;
    logic [XLEN-1:0] imm_op = '0;
    logic            fetch_misaligned;

    int errors = 0;
    int checks = 0;
    logic [31:0] mpc;
    int cyc;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .pcsrc(pcsrc), .imm_op(imm_op),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            fetch_misaligned !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state req=%b vld=%b mis=%b instr=%h ipc=%h",
                     imem_req, instr_valid, fetch_misaligned, instr, instr_pc);
        end
        rst = 1'b0;
        mpc = RPC;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++;
            $display("FAIL reset_restart req=%b addr=%h want 1/%h",
                     imem_req, imem_addr, RPC);
        end
    endtask

    // One full fetch; model PC mpc is updated from pcsrc/imm on acceptance.
    task automatic do_fetch(input int gd, input int rd, input int hd,
                            input logic [1:0] ps, input logic [31:0] imm,
                            input logic [31:0] data, output int ncyc);
        int n;
        logic [31:0] nxt;
        ncyc = 0;
        n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
            ncyc++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout req=%b want 1", imem_req);
            return;
        end
        checks++;
        if (imem_addr !== mpc) begin
            errors++;
            $display("FAIL fetch_addr got %h want %h", imem_addr, mpc);
        end
        for (int i = 0; i < gd; i++) begin
            imem_gnt = 1'b0;
            imem_rdata = $urandom;
            tick();
            ncyc++;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== mpc) begin
                errors++;
                $display("FAIL req_hold req=%b addr=%h want 1/%h",
                         imem_req, imem_addr, mpc);
            end
        end
        imem_gnt = 1'b1;
        tick();
        ncyc++;
        imem_gnt = 1'b0;
        for (int i = 0; i < rd; i++) begin
            imem_rdata = $urandom;
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_quiet req=%b vld=%b want 0/0",
                         imem_req, instr_valid);
            end
            tick();
            ncyc++;
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL second_req req=%b want 0", imem_req);
        end
        imem_rvalid = 1'b1;
        imem_rdata = data;
        tick();
        ncyc++;
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        for (int i = 0; i <= hd; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== data ||
                instr_pc !== mpc || imem_req !== 1'b0 ||
                op !== data[6:0] || funct3 !== data[14:12] ||
                funct7_5 !== data[30]) begin
                errors++;
                $display("FAIL hold vld=%b instr=%h ipc=%h op=%h f3=%h f7=%b want 1/%h/%h",
                         instr_valid, instr, instr_pc, op, funct3,
                         funct7_5, data, mpc);
            end
            if (i < hd) begin
                instr_ready = 1'b0;
                pcsrc = 2'($urandom);
                imm_op = $urandom;
                tick();
                ncyc++;
            end
        end
        instr_ready = 1'b1;
        pcsrc = ps;
        imm_op = imm;
        tick();
        ncyc++;
        instr_ready = 1'b0;
        pcsrc = 2'($urandom);
        imm_op = $urandom;
        case (ps)
            2'b01:   nxt = mpc + imm;
            2'b10:   nxt = imm;
            default: nxt = mpc + 32'd4;
        endcase
        checks++;
        if (nxt % 4 != 0) begin
            if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 ||
                instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_entry mis=%b req=%b vld=%b want 1/0/0",
                         fetch_misaligned, imem_req, instr_valid);
            end
        end else begin
            if (imem_req !== 1'b1 || imem_addr !== nxt ||
                fetch_misaligned !== 1'b0) begin
                errors++;
                $display("FAIL next_pc req=%b addr=%h mis=%b want 1/%h/0",
                         imem_req, imem_addr, fetch_misaligned, nxt);
            end
        end
        mpc = nxt;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        want = 32'h0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_addr !== want) begin
                errors++;
                $display("FAIL seq_addr got %h want %h", imem_addr, want);
            end
            do_fetch(0, 0, 0, 2'b00, $urandom, $urandom, cyc);
            checks++;
            if (cyc != 3) begin
                errors++;
                $display("FAIL seq_cadence got %0d want 3", cyc);
            end
            want = want + 32'd4;
        end
    endtask

    task automatic test_branch();
        do_fetch(0, 0, 0, 2'b10, 32'h10, 32'h0000_0063, cyc);
        do_fetch(0, 0, 0, 2'b01, 32'hFFFF_FFF8, 32'h0000_0063, cyc);
        checks++;
        if (imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL branch_target got %h want 00000008", imem_addr);
        end
        do_fetch(0, 0, 0, 2'b10, 32'h200, 32'h0000_0067, cyc);
        checks++;
        if (imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL jalr_target got %h want 00000200", imem_addr);
        end
        do_fetch(1, 1, 0, 2'b11, 32'h1234, $urandom, cyc);
    endtask

    task automatic test_backpressure();
        logic [31:0] a0;
        a0 = mpc;
        do_fetch(3, 4, 5, 2'b00, 32'h0, 32'h4000_5033, cyc);
        checks++;
        if (op !== 7'h33 || funct3 !== 3'b101 || funct7_5 !== 1'b1) begin
            errors++;
            $display("FAIL fields op=%h f3=%b f7=%b want 33/101/1",
                     op, funct3, funct7_5);
        end
        checks++;
        if (cyc != 3 + 3 + 4 + 5 || imem_addr !== a0 + 32'd4) begin
            errors++;
            $display("FAIL bp_cycles got %0d addr %h want 15/%h",
                     cyc, imem_addr, a0 + 32'd4);
        end
    endtask

    task automatic test_wrap();
        do_fetch(0, 0, 0, 2'b10, 32'hFFFF_FFFC, $urandom, cyc);
        do_fetch(0, 1, 0, 2'b00, 32'h0, $urandom, cyc);
        checks++;
        if (imem_addr !== 32'h0 || fetch_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL wrap addr=%h mis=%b want 0/0",
                     imem_addr, fetch_misaligned);
        end
    endtask

    task automatic test_random();
        logic [1:0]  ps;
        logic [31:0] imm;
        for (int k = 0; k < 40; k++) begin
            ps = 2'($urandom);
            if (ps == 2'b01)
                imm = (($urandom & 32'hFFC) - 32'h800);
            else
                imm = $urandom & 32'hFFFF_FFFC;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), ps, imm, $urandom, cyc);
        end
    endtask

    task automatic test_misaligned();
        do_fetch(0, 0, 1, 2'b10, 32'h102, $urandom, cyc);
        for (int i = 0; i < 22; i++) begin
            imem_gnt = 1'($urandom);
            imem_rvalid = 1'($urandom);
            instr_ready = 1'($urandom);
            imem_rdata = $urandom;
            tick();
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                fetch_misaligned !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky req=%b vld=%b mis=%b want 0/0/1",
                         imem_req, instr_valid, fetch_misaligned);
            end
        end
        apply_reset();
        do_fetch(0, 0, 0, 2'b00, 32'h0, $urandom, cyc);
    endtask

    task automatic test_async_reset();
        do_fetch(0, 0, 0, 2'b00, 32'h0, 32'h1234_5678, cyc);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0 ||
            fetch_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL async_reset req=%b vld=%b instr=%h ipc=%h want 0/0/0/0",
                     imem_req, instr_valid, instr, instr_pc);
        end
        tick();
        rst = 1'b0;
        mpc = RPC;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== RPC || instr !== 32'h0) begin
            errors++;
            $display("FAIL stale_rvalid vld=%b req=%b addr=%h instr=%h want 0/1/%h/0",
                     instr_valid, imem_req, imem_addr, instr, RPC);
        end
        do_fetch(1, 0, 0, 2'b00, 32'h0, 32'hCAFE_0013, cyc);
    endtask

    initial begin
        mpc = RPC;
        test_reset();
        test_sequential();
        test_branch();
        test_backpressure();
        test_wrap();
        test_random();
        test_async_reset();
        test_misaligned();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
